// File: rtl/lcd_init_writer_pkg.sv
// Shared types and constants for the HD44780-class LCD writer.
// Contents: FSM state encoding, hold-interval select, LCD command bytes,
// and the rule mapping a user write to the hold interval it needs.
package lcd_pkg;

    localparam int unsigned STEP_W = 3;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(7);

    typedef enum logic [2:0] {
        PWR_WAIT,
        LOAD,
        PULSE,
        WAIT,
        IDLE
    } state_t;

    typedef enum logic [1:0] {
        H42,
        H100,
        H1640,
        H4100
    } hold_t;

    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] HOME     = 8'h02;
    localparam logic [7:0] WAKE     = 8'h30;
    localparam logic [7:0] DISP_OFF = 8'h08;

    // Clear and home-family commands need the long execution time.
    function automatic hold_t user_hold(input logic rs, input logic [7:0] data);
        if (!rs && (data == CLEAR || data == HOME || data == 8'h03)) begin
            return H1640;
        end
        return H42;
    endfunction

endpackage

// File: rtl/lcd_init_writer_rom.sv
// Power-on init table: step index -> {byte to write, hold interval}.
// Ports: step (in, 3), rom_byte (out, 8), rom_hold (out, hold_t).
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter logic [7:0] INIT_FUNC  = 8'h38,
    parameter logic [7:0] INIT_ENTRY = 8'h06,
    parameter logic [7:0] INIT_DISP  = 8'h0C
) (
    input  logic [STEP_W-1:0] step,
    output logic [7:0]        rom_byte,
    output hold_t             rom_hold
);

    always_comb begin
        rom_byte = WAKE;
        rom_hold = H42;
        case (step)
            3'd0: begin rom_byte = WAKE;       rom_hold = H4100; end
            3'd1: begin rom_byte = WAKE;       rom_hold = H100;  end
            3'd2: begin rom_byte = WAKE;       rom_hold = H100;  end
            3'd3: begin rom_byte = INIT_FUNC;  rom_hold = H42;   end
            3'd4: begin rom_byte = DISP_OFF;   rom_hold = H42;   end
            3'd5: begin rom_byte = CLEAR;      rom_hold = H1640; end
            3'd6: begin rom_byte = INIT_ENTRY; rom_hold = H42;   end
            3'd7: begin rom_byte = INIT_DISP;  rom_hold = H42;   end
            default: begin rom_byte = WAKE;    rom_hold = H42;   end
        endcase
    end

endmodule

// File: rtl/lcd_init_writer.sv
// HD44780-class 8-bit write-only LCD driver: runs the power-on init sequence,
// then forwards single-byte command/data writes with datasheet timing.
// Ports: clk, rst (sync active-high); flag_* elapsed-time flags in and
// flag_rst restart pulse out (external interval timer); wr_valid/wr_rs/
// wr_data/wr_ready write handshake; init_done; lcd_rs/lcd_rw/lcd_en/lcd_data pins.
module lcd_init_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 3,
    parameter logic [7:0]  INIT_FUNC  = 8'h38,
    parameter logic [7:0]  INIT_ENTRY = 8'h06,
    parameter logic [7:0]  INIT_DISP  = 8'h0C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flag_250ns,
    input  logic       flag_42us,
    input  logic       flag_100us,
    input  logic       flag_1640us,
    input  logic       flag_4100us,
    input  logic       flag_15000us,
    output logic       flag_rst,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int unsigned CNT_W = (SETUP_CYC > 2) ? $clog2(SETUP_CYC) : 1;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    hold_t               hold_q, hold_d;
    logic                flag_rst_d, wr_ready_d, init_done_d;
    logic                lcd_rs_d, lcd_en_d;
    logic [7:0]          lcd_data_d;

    logic [STEP_W-1:0]   rom_step;
    logic [7:0]          rom_byte;
    hold_t               rom_hold;
    logic                hold_hit;

    // Look ahead one step while waiting so the next byte is ready on LOAD entry.
    assign rom_step = (state_q == WAIT) ? step_q + STEP_W'(1) : STEP_W'(0);
    assign lcd_rw   = 1'b0;

    lcd_init_rom #(
        .INIT_FUNC  (INIT_FUNC),
        .INIT_ENTRY (INIT_ENTRY),
        .INIT_DISP  (INIT_DISP)
    ) u_rom (
        .step     (rom_step),
        .rom_byte (rom_byte),
        .rom_hold (rom_hold)
    );

    // Hold-interval flag for the byte in flight.
    always_comb begin
        hold_hit = 1'b0;
        case (hold_q)
            H42:     hold_hit = flag_42us;
            H100:    hold_hit = flag_100us;
            H1640:   hold_hit = flag_1640us;
            H4100:   hold_hit = flag_4100us;
            default: hold_hit = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PWR_WAIT;
            step_q    <= '0;
            cnt_q     <= '0;
            hold_q    <= H4100;
            flag_rst  <= 1'b1;
            wr_ready  <= 1'b0;
            init_done <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            flag_rst  <= flag_rst_d;
            wr_ready  <= wr_ready_d;
            init_done <= init_done_d;
            lcd_rs    <= lcd_rs_d;
            lcd_en    <= lcd_en_d;
            lcd_data  <= lcd_data_d;
        end
    end

    // Next state and next registered outputs. Flags are only trusted while
    // flag_rst is low, i.e. after the timer has actually been restarted.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        flag_rst_d  = 1'b0;
        wr_ready_d  = 1'b0;
        init_done_d = init_done;
        lcd_rs_d    = lcd_rs;
        lcd_en_d    = 1'b0;
        lcd_data_d  = lcd_data;

        case (state_q)
            PWR_WAIT: begin
                if (!flag_rst && flag_15000us) begin
                    state_d    = LOAD;
                    step_d     = '0;
                    cnt_d      = '0;
                    hold_d     = rom_hold;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = rom_byte;
                end
            end

            LOAD: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d  = PULSE;
                    lcd_en_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    flag_rst_d = (cnt_q == CNT_W'(SETUP_CYC - 2));
                end
            end

            PULSE: begin
                lcd_en_d = 1'b1;
                if (flag_rst) begin
                    state_d  = WAIT;
                    lcd_en_d = 1'b0;
                end else if (flag_250ns) begin
                    flag_rst_d = 1'b1;
                end
            end

            WAIT: begin
                if (hold_hit) begin
                    if (!init_done && step_q != LAST_STEP) begin
                        state_d    = LOAD;
                        step_d     = step_q + STEP_W'(1);
                        cnt_d      = '0;
                        hold_d     = rom_hold;
                        lcd_rs_d   = 1'b0;
                        lcd_data_d = rom_byte;
                    end else begin
                        state_d     = IDLE;
                        wr_ready_d  = 1'b1;
                        init_done_d = 1'b1;
                    end
                end
            end

            IDLE: begin
                wr_ready_d = 1'b1;
                if (wr_valid && wr_ready) begin
                    state_d    = LOAD;
                    cnt_d      = '0;
                    hold_d     = user_hold(wr_rs, wr_data);
                    lcd_rs_d   = wr_rs;
                    lcd_data_d = wr_data;
                    wr_ready_d = 1'b0;
                end
            end

            default: begin
                state_d = PWR_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_init_writer.sv
// Self-checking bench for lcd_init_writer with a scaled-down interval timer.
module tb_lcd_init_writer;

    localparam int unsigned SETUP  = 3;
    localparam int unsigned T250   = 13;
    localparam int unsigned T42    = 40;
    localparam int unsigned T100   = 60;
    localparam int unsigned T1640  = 150;
    localparam int unsigned T4100  = 300;
    localparam int unsigned T15000 = 500;
    localparam int unsigned MIN_EN = 13;

    localparam logic [7:0]  INIT_B [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    localparam int unsigned INIT_H [8] = '{T4100, T100, T100, T42, T42, T1640, T42, T42};

    typedef struct {
        logic        rs;
        logic [7:0]  b;
        int unsigned hold;
        bit          user;
    } strobe_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flag_250ns, flag_42us, flag_100us, flag_1640us, flag_4100us, flag_15000us;
    logic       flag_rst;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, init_done, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned tmr = 0;

    always #10 clk = ~clk;

    lcd_init_writer dut (
        .clk          (clk),
        .rst          (rst),
        .flag_250ns   (flag_250ns),
        .flag_42us    (flag_42us),
        .flag_100us   (flag_100us),
        .flag_1640us  (flag_1640us),
        .flag_4100us  (flag_4100us),
        .flag_15000us (flag_15000us),
        .flag_rst     (flag_rst),
        .wr_valid     (wr_valid),
        .wr_rs        (wr_rs),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .init_done    (init_done),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_en       (lcd_en),
        .lcd_data     (lcd_data)
    );

    // Interval timer model: cleared on every edge that sees flag_rst, sticky flags.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flag_rst !== 1'b0) tmr <= 0;
        else if (tmr < T15000) tmr <= tmr + 1;
    end

    assign flag_250ns   = (tmr >= T250);
    assign flag_42us    = (tmr >= T42);
    assign flag_100us   = (tmr >= T100);
    assign flag_1640us  = (tmr >= T1640);
    assign flag_4100us  = (tmr >= T4100);
    assign flag_15000us = (tmr >= T15000);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic strobe_t mk(input logic rs, input logic [7:0] b, input int unsigned hold,
                                   input bit user);
        strobe_t s;
        s.rs = rs; s.b = b; s.hold = hold; s.user = user;
        return s;
    endfunction

    // Reference model: expected strobes, their order and their timing.
    strobe_t     exp_q[$];
    strobe_t     e;
    logic        prev_en = 1'b0, prev_rdy = 1'b0, prev_rs = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    int unsigned stable = 0, fall_cyc = 0, rise_cyc = 0, accept_edge = 0, rise_idx = 0;
    int unsigned early_rdy = 0, prev_hold = T15000;
    bit          moved = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) exp_q.push_back(mk(1'b0, INIT_B[i], INIT_H[i], 1'b0));
            fall_cyc  = cyc + 2;
            prev_hold = T15000;
            rise_idx  = 0;
        end else begin
            if (wr_ready && !init_done) early_rdy++;
            if (wr_valid && wr_ready) begin
                accept_edge = cyc + 1;
                exp_q.push_back(mk(wr_rs, wr_data,
                    (!wr_rs && (wr_data inside {8'h01, 8'h02, 8'h03})) ? T1640 : T42, 1'b1));
            end
            if (lcd_en && !prev_en) begin
                check("setup_stable", 32'(stable >= SETUP), 1);
                check("strobe_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("strobe_byte", {lcd_rs, lcd_data}, {e.rs, e.b});
                    if (e.user) check("accept_to_en", cyc - accept_edge, SETUP);
                    else        check("gap_to_en", cyc - fall_cyc, prev_hold + 1 + SETUP);
                    prev_hold = e.hold;
                end
                rise_cyc = cyc;
                rise_idx++;
                moved = 1'b0;
            end
            if (lcd_en && prev_en && {lcd_rs, lcd_data} != {prev_rs, prev_data}) moved = 1'b1;
            if (!lcd_en && prev_en) begin
                check("en_high_len", 32'((cyc - rise_cyc) >= MIN_EN), 1);
                check("data_held_in_en", 32'(moved), 0);
                fall_cyc = cyc;
            end
            if (wr_ready && !prev_rdy) check("ready_gap", cyc - fall_cyc, prev_hold + 1);
        end
        if (lcd_en) stable = 0;
        else if ({lcd_rs, lcd_data} == {prev_rs, prev_data}) stable++;
        else stable = 1;
        prev_en   = lcd_en;
        prev_rdy  = wr_ready;
        prev_rs   = lcd_rs;
        prev_data = lcd_data;
    end

    // Run init while throwing stray write requests at the block.
    task automatic run_init();
        int n = 0;
        while (!init_done && n < 5000) begin
            @(posedge clk); #1;
            wr_valid = ($urandom % 6 == 0);
            wr_rs    = 1'($urandom);
            wr_data  = 8'($urandom);
            @(negedge clk);
            n++;
        end
        check("init_done", init_done, 1);
        check("ready_after_init", wr_ready, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input bit keep);
        int n = 0;
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        @(negedge clk);
        while (!wr_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", wr_ready, 1);
        @(posedge clk); #1;
        if (!keep) wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        wr_valid = 1'b0;
        @(negedge clk);
        while (!(wr_ready && !lcd_en) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", wr_ready, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_en_low", lcd_en, 0);
        check("rst_flag_rst", flag_rst, 1);
        check("rst_init_done", init_done, 0);
        check("rst_ready", wr_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] d;
        logic [7:0] pick [3];
        pick[0] = 8'h01; pick[1] = 8'h02; pick[2] = 8'h03;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flag_rst", flag_rst, 1);
        check("reset_en", lcd_en, 0);
        check("reset_rs", lcd_rs, 0);
        check("reset_rw", lcd_rw, 0);
        check("reset_data", lcd_data, 8'h00);
        check("reset_ready", wr_ready, 0);
        check("reset_init_done", init_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_init();
        send(1'b1, 8'h41, 1'b0);
        send(1'b0, 8'h01, 1'b0);
        send(1'b0, 8'h80, 1'b0);
        send(1'b1, 8'h48, 1'b1);
        send(1'b1, 8'h49, 1'b0);
        for (int i = 0; i < 12; i++) begin
            case ($urandom % 4)
                0:       d = pick[$urandom % 3];
                1:       d = 8'h00;
                default: d = 8'($urandom);
            endcase
            send(1'($urandom), d, ($urandom % 3 == 0));
        end
        wait_idle();

        // Reset from IDLE drops init_done and restarts init.
        pulse_reset();

        // Abort the init sequence while step 3 is strobing.
        n = 0;
        @(negedge clk);
        while (!(lcd_en && rise_idx == 4) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("step3_reached", rise_idx, 4);
        check("step3_byte", lcd_data, 8'h38);
        pulse_reset();

        run_init();
        send(1'b0, 8'h02, 1'b0);
        send(1'b1, 8'h5A, 1'b0);
        wait_idle();
        check("no_ready_in_init", early_rdy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
